// File: rtl/fetch_stage_if.sv
// Shared fetch-packet types plus the I-cache / instruction-buffer bundle
// driven by the fetch stage (master) and its environment (slave).
package fetch_pkg;
   localparam int WAY         = 4;
   localparam int WAY_CNT_LEN = 3;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
   } fetch_packet_t;
endpackage

interface fetch_stage_if;
   import fetch_pkg::*;

   logic [31:0]             icache_req_pc;
   logic                    icache_req_valid;
   logic [WAY-1:0]          icache_hit;
   logic [WAY-1:0][31:0]    icache_inst;
   fetch_packet_t [WAY-1:0] fetch_out;
   logic [WAY_CNT_LEN-1:0]  inst_buff_num_fetched;

   modport master (
      output icache_req_pc, icache_req_valid, fetch_out,
      input  icache_hit, icache_inst, inst_buff_num_fetched
   );

   modport slave (
      input  icache_req_pc, icache_req_valid, fetch_out,
      output icache_hit, icache_inst, inst_buff_num_fetched
   );
endinterface

// File: rtl/fetch_stage.sv
// PC generator and instruction fetch stage: packs consecutive I-cache hits into
// lanes for the instruction buffer, handles miss stalls, flush redirects and WFI halt.
module fetch_stage_checker #(
   parameter int CNT_W = 3
) (
   input logic             clock,
   input logic             reset,
   input logic             fetch_flush,
   input logic [CNT_W-1:0] num_fetched,
   input logic [CNT_W-1:0] n_valid
);
   // The buffer may only accept lanes that were actually offered.
   property p_accept_within_valid;
      @(posedge clock) disable iff (reset || fetch_flush) num_fetched <= n_valid;
   endproperty
   a_accept_within_valid: assert property (p_accept_within_valid);
endmodule

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] WFI_INST = 32'h1050_0073
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          fetch_flush,
   input  logic [31:0]   flush_target_pc,
   fetch_stage_if.master fif,
   output logic          halted,
   output logic [31:0]   miss_cycles
);
   import fetch_pkg::*;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_MISS = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [1:0]             state_r, state_nxt_s;
   logic [31:0]            pc_r, pc_nxt_s, pc_adv_s;
   logic [31:0]            miss_cnt_r;
   logic                   req_valid_s;
   logic [WAY-1:0]         lane_valid_s;
   logic [WAY_CNT_LEN-1:0] n_valid_s;
   logic                   wfi_accept_s;

   assign req_valid_s          = (state_r != ST_HALT);
   assign fif.icache_req_valid = req_valid_s;
   assign fif.icache_req_pc    = pc_r;
   assign halted               = (state_r == ST_HALT);
   assign miss_cycles          = miss_cnt_r;
   assign pc_adv_s = pc_r + {{(30 - WAY_CNT_LEN){1'b0}}, fif.inst_buff_num_fetched, 2'b00};

   // Lane qualification: a contiguous run of hits, truncated just after the first WFI.
   always_comb begin
      logic open_v;
      open_v       = req_valid_s;
      lane_valid_s = '0;
      n_valid_s    = '0;
      wfi_accept_s = 1'b0;
      for (int i = 0; i < WAY; i++) begin
         lane_valid_s[i] = open_v & fif.icache_hit[i];
         open_v          = lane_valid_s[i] & (fif.icache_inst[i] != WFI_INST);
         n_valid_s       = n_valid_s + {{(WAY_CNT_LEN - 1){1'b0}}, lane_valid_s[i]};
         wfi_accept_s    = wfi_accept_s | (lane_valid_s[i] & (fif.icache_inst[i] == WFI_INST)
                           & (WAY_CNT_LEN'(i) < fif.inst_buff_num_fetched));
      end
   end

   // Fetch packet lanes; no branch prediction, so NPC is always PC+4.
   always_comb begin
      for (int i = 0; i < WAY; i++) begin
         if (lane_valid_s[i]) begin
            fif.fetch_out[i].valid = 1'b1;
            fif.fetch_out[i].inst  = fif.icache_inst[i];
            fif.fetch_out[i].pc    = pc_r + (32'(i) << 2);
            fif.fetch_out[i].npc   = pc_r + (32'(i) << 2) + 32'd4;
         end else begin
            fif.fetch_out[i] = '0;
         end
      end
   end

   // Next state / PC; a flush overrides everything and drops the accept count.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      if (fetch_flush) begin
         state_nxt_s = ST_RUN;
         pc_nxt_s    = flush_target_pc & ~32'h0000_0003;
      end else begin
         case (state_r)
            ST_RUN, ST_MISS: begin
               if (wfi_accept_s) begin
                  state_nxt_s = ST_HALT;
                  pc_nxt_s    = pc_adv_s;
               end else if (!fif.icache_hit[0]) begin
                  state_nxt_s = ST_MISS;
                  pc_nxt_s    = pc_r;
               end else begin
                  state_nxt_s = ST_RUN;
                  pc_nxt_s    = pc_adv_s;
               end
            end
            ST_HALT: begin
               state_nxt_s = ST_HALT;
               pc_nxt_s    = pc_r;
            end
            default: begin
               state_nxt_s = ST_RUN;
               pc_nxt_s    = pc_r;
            end
         endcase
      end
   end

   // State, PC and saturating miss-cycle counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_RUN;
         pc_r       <= RESET_PC;
         miss_cnt_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         if ((state_r == ST_MISS) && (miss_cnt_r != 32'hFFFF_FFFF)) begin
            miss_cnt_r <= miss_cnt_r + 32'd1;
         end else begin
            miss_cnt_r <= miss_cnt_r;
         end
      end
   end

   fetch_stage_checker #(.CNT_W(WAY_CNT_LEN)) u_checker (
      .clock       (clock),
      .reset       (reset),
      .fetch_flush (fetch_flush),
      .num_fetched (fif.inst_buff_num_fetched),
      .n_valid     (n_valid_s)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural model.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam logic [31:0] WFI = 32'h1050_0073;

   logic        clock;
   logic        reset;
   logic        fetch_flush;
   logic [31:0] flush_target_pc;
   logic        halted;
   logic [31:0] miss_cycles;

   fetch_stage_if fif();

   fetch_stage #(.RESET_PC(32'h0000_0000), .WFI_INST(WFI)) dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_flush     (fetch_flush),
      .flush_target_pc (flush_target_pc),
      .fif             (fif),
      .halted          (halted),
      .miss_cycles     (miss_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec  = 0;
   int n_miss = 0;

   // Model state: spec-level mode flags, PC and miss counter
   logic        m_halt, m_miss;
   logic [31:0] m_pc, m_cnt;
   fetch_packet_t [WAY-1:0] exp_lanes;
   int          exp_nval;

   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      r = $urandom;
      if (r == WFI) r = r ^ 32'h1;
      return r;
   endfunction

   // Expected lanes: walk hits from lane 0, stop at a miss or just after a WFI.
   function automatic void expect_now();
      logic [31:0] lpc;
      exp_lanes = '0;
      exp_nval  = 0;
      if (!m_halt) begin
         for (int i = 0; i < WAY; i++) begin
            if (!fif.icache_hit[i]) break;
            lpc = m_pc + 32'(4 * i);
            exp_lanes[i].valid = 1'b1;
            exp_lanes[i].inst  = fif.icache_inst[i];
            exp_lanes[i].pc    = lpc;
            exp_lanes[i].npc   = lpc + 32'd4;
            exp_nval++;
            if (fif.icache_inst[i] == WFI) break;
         end
      end
   endfunction

   function automatic void model_step();
      logic wfi_acc;
      int   n;
      expect_now();
      n = int'(fif.inst_buff_num_fetched);
      if (reset) begin
         m_halt = 1'b0; m_miss = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
      end else begin
         if (m_miss && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         if (fetch_flush) begin
            m_halt = 1'b0; m_miss = 1'b0; m_pc = flush_target_pc & ~32'h3;
         end else if (!m_halt) begin
            wfi_acc = 1'b0;
            for (int i = 0; i < n && i < WAY; i++)
               if (exp_lanes[i].valid && exp_lanes[i].inst == WFI) wfi_acc = 1'b1;
            if (wfi_acc) begin
               m_halt = 1'b1; m_miss = 1'b0; m_pc = m_pc + 32'(4 * n);
            end else if (!fif.icache_hit[0]) begin
               m_miss = 1'b1;
            end else begin
               m_miss = 1'b0; m_pc = m_pc + 32'(4 * n);
            end
         end
      end
   endfunction

   task automatic drive(input logic [WAY-1:0] h, input logic [WAY-1:0][31:0] ins,
                        input logic [2:0] n, input logic fl, input logic [31:0] tg);
      fif.icache_hit            = h;
      fif.icache_inst           = ins;
      fif.inst_buff_num_fetched = n;
      fetch_flush               = fl;
      flush_target_pc           = tg;
      #1;
      expect_now();
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      expect_now();
   endtask

   function automatic logic [WAY-1:0][31:0] rnd_insts();
      logic [WAY-1:0][31:0] v;
      for (int i = 0; i < WAY; i++) v[i] = rnd_inst();
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive(4'b1111, rnd_insts(), 3'd0, 1'b0, 32'h0);
      tick(); tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if (fif.icache_req_pc !== 32'h0 || fif.icache_req_valid !== 1'b1 || halted !== 1'b0 || miss_cycles !== 32'h0) begin
         n_miss++;
         $display("FAIL reset: pc=%h valid=%b halted=%b miss=%0d, want pc=0 valid=1 halted=0 miss=0",
                  fif.icache_req_pc, fif.icache_req_valid, halted, miss_cycles);
      end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 4; k++) begin
         drive(4'b1111, rnd_insts(), 3'd4, 1'b0, 32'h0);
         n_vec++;
         if (fif.icache_req_pc !== 32'(16 * k) || fif.fetch_out !== exp_lanes) begin
            n_miss++;
            $display("FAIL stream[%0d]: pc=%h lanes=%h, want pc=%h lanes=%h", k,
                     fif.icache_req_pc, fif.fetch_out, 32'(16 * k), exp_lanes);
         end
         tick();
      end
   endtask

   task automatic test_partial_hit();
      logic [31:0] p0;
      p0 = m_pc;
      drive(4'b1011, rnd_insts(), 3'd2, 1'b0, 32'h0);
      n_vec++;
      if (fif.fetch_out !== exp_lanes || fif.fetch_out[2] !== '0 || fif.fetch_out[3] !== '0
          || fif.fetch_out[1].valid !== 1'b1) begin
         n_miss++;
         $display("FAIL partial_lanes: got %h want %h", fif.fetch_out, exp_lanes);
      end
      tick();
      n_vec++;
      if (fif.icache_req_pc !== p0 + 32'd8 || halted !== 1'b0 || fif.icache_req_valid !== 1'b1) begin
         n_miss++;
         $display("FAIL partial_pc: got %h want %h", fif.icache_req_pc, p0 + 32'd8);
      end
   endtask

   task automatic test_miss();
      logic [31:0] p0, c0;
      p0 = m_pc;
      c0 = m_cnt;
      for (int k = 0; k < 3; k++) begin
         drive(4'b1110, rnd_insts(), 3'd0, 1'b0, 32'h0);
         n_vec++;
         if (fif.icache_req_pc !== p0 || fif.fetch_out !== '0 || fif.icache_req_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL miss_hold[%0d]: pc=%h lanes=%h want pc=%h", k, fif.icache_req_pc, fif.fetch_out, p0);
         end
         tick();
      end
      drive(4'b1111, rnd_insts(), 3'd1, 1'b0, 32'h0);
      n_vec++;
      if (fif.fetch_out[0].valid !== 1'b1 || fif.fetch_out !== exp_lanes || fif.icache_req_pc !== p0) begin
         n_miss++;
         $display("FAIL miss_resume: lanes=%h want %h", fif.fetch_out, exp_lanes);
      end
      tick();
      n_vec++;
      if (miss_cycles !== c0 + 32'd3 || fif.icache_req_pc !== p0 + 32'd4) begin
         n_miss++;
         $display("FAIL miss_count: cnt=%0d pc=%h want cnt=%0d pc=%h", miss_cycles, fif.icache_req_pc,
                  c0 + 32'd3, p0 + 32'd4);
      end
   endtask

   task automatic test_wfi();
      logic [WAY-1:0][31:0] ins;
      drive(4'b1111, rnd_insts(), 3'd0, 1'b1, 32'h0000_0040);
      tick();
      ins = rnd_insts();
      ins[1] = WFI;
      drive(4'b1111, ins, 3'd2, 1'b0, 32'h0);
      n_vec++;
      if (fif.fetch_out[2] !== '0 || fif.fetch_out[3] !== '0 || fif.fetch_out[1].valid !== 1'b1
          || fif.fetch_out !== exp_lanes) begin
         n_miss++;
         $display("FAIL wfi_lanes: got %h want %h", fif.fetch_out, exp_lanes);
      end
      tick();
      n_vec++;
      if (halted !== 1'b1 || fif.icache_req_valid !== 1'b0 || fif.fetch_out !== '0 || fif.icache_req_pc !== 32'h48) begin
         n_miss++;
         $display("FAIL wfi_halt: halted=%b valid=%b pc=%h want 1 0 00000048", halted, fif.icache_req_valid, fif.icache_req_pc);
      end
      drive(4'b1111, rnd_insts(), 3'd0, 1'b1, 32'h0000_0100);
      tick();
      n_vec++;
      if (halted !== 1'b0 || fif.icache_req_valid !== 1'b1 || fif.icache_req_pc !== 32'h100) begin
         n_miss++;
         $display("FAIL wfi_flush: halted=%b pc=%h want 0 00000100", halted, fif.icache_req_pc);
      end
   endtask

   task automatic test_flush_same_cycle();
      drive(4'b1111, rnd_insts(), 3'd3, 1'b1, 32'h0000_0203);
      tick();
      n_vec++;
      if (fif.icache_req_pc !== 32'h200 || halted !== 1'b0) begin
         n_miss++;
         $display("FAIL flush_adv: pc=%h want 00000200", fif.icache_req_pc);
      end
   endtask

   task automatic test_wrap_and_reset();
      drive(4'b1111, rnd_insts(), 3'd0, 1'b1, 32'hFFFF_FFF8);
      tick();
      drive(4'b1111, rnd_insts(), 3'd4, 1'b0, 32'h0);
      n_vec++;
      if (fif.fetch_out[2].pc !== 32'h0 || fif.fetch_out[1].npc !== 32'h0 || fif.fetch_out !== exp_lanes) begin
         n_miss++;
         $display("FAIL wrap_lanes: got %h want %h", fif.fetch_out, exp_lanes);
      end
      tick();
      n_vec++;
      if (fif.icache_req_pc !== 32'h8) begin
         n_miss++;
         $display("FAIL wrap_pc: pc=%h want 00000008", fif.icache_req_pc);
      end
      drive(4'b0000, rnd_insts(), 3'd0, 1'b0, 32'h0);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if (fif.icache_req_pc !== 32'h0 || halted !== 1'b0 || miss_cycles !== 32'h0 || fif.icache_req_valid !== 1'b1) begin
         n_miss++;
         $display("FAIL miss_reset: pc=%h halted=%b cnt=%0d want 0 0 0", fif.icache_req_pc, halted, miss_cycles);
      end
   endtask

   task automatic test_random();
      logic [WAY-1:0]       h;
      logic [WAY-1:0][31:0] ins;
      logic                 fl;
      for (int k = 0; k < 400; k++) begin
         h = ($urandom_range(0, 3) == 0) ? WAY'($urandom) : 4'b1111;
         ins = rnd_insts();
         for (int i = 0; i < WAY; i++) if ($urandom_range(0, 7) == 0) ins[i] = WFI;
         fl = ($urandom_range(0, 15) == 0) || (m_halt && $urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 63) == 0);
         drive(h, ins, 3'd0, fl, $urandom);
         fif.inst_buff_num_fetched = 3'($urandom_range(0, exp_nval));
         #1;
         expect_now();
         n_vec++;
         if (fif.fetch_out !== exp_lanes || fif.icache_req_pc !== m_pc || fif.icache_req_valid !== !m_halt
             || halted !== m_halt || miss_cycles !== m_cnt) begin
            n_miss++;
            $display("FAIL random[%0d]: pc=%h v=%b h=%b cnt=%0d lanes=%h want pc=%h v=%b h=%b cnt=%0d lanes=%h", k,
                     fif.icache_req_pc, fif.icache_req_valid, halted, miss_cycles, fif.fetch_out,
                     m_pc, !m_halt, m_halt, m_cnt, exp_lanes);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fetch_flush = 1'b0;
      flush_target_pc = 32'h0;
      fif.icache_hit = '0;
      fif.icache_inst = '0;
      fif.inst_buff_num_fetched = '0;
      m_halt = 1'b0; m_miss = 1'b0; m_pc = 32'h0; m_cnt = 32'h0;
      @(posedge clock);
      #1;
      test_reset();
      test_stream();
      test_partial_hit();
      test_miss();
      test_wfi();
      test_flush_same_cycle();
      test_wrap_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
